// File: rtl/program_counter.sv
// Program counter register: loads the externally computed next address each cycle.
// Optional macro PC_WORD_ALIGN_EN forces loaded and reset addresses to word alignment.
module program_counter #(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic [WIDTH-1:0] next_addr,
   output logic [WIDTH-1:0] out_addr,
   input  logic             clk,
   input  logic             reset
);

`ifdef PC_WORD_ALIGN_EN
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(2'b11));
`endif

   // Applies the configured alignment policy to an address.
   function automatic logic [WIDTH-1:0] align_addr(input logic [WIDTH-1:0] addr);
`ifdef PC_WORD_ALIGN_EN
      align_addr = addr & ALIGN_MASK;
`else
      align_addr = addr;
`endif
   endfunction

   localparam logic [WIDTH-1:0] RESET_ADDR = align_addr(RESET_VALUE);

   logic [WIDTH-1:0] load_addr_s;
   logic [WIDTH-1:0] pc_r;

   // Value presented to the register on the next edge.
   always_comb begin
      load_addr_s = align_addr(next_addr);
   end

   // PC state register; reset takes priority over any coincident clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_r <= RESET_ADDR;
      end else begin
         pc_r <= load_addr_s;
      end
   end

   assign out_addr = pc_r;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios followed by
// randomized traffic compared against a behavioural model.
module tb_program_counter;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] next_addr = 32'h0;
   logic [31:0] out_addr;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] model_pc;

   program_counter #(.WIDTH(32), .RESET_VALUE(RV)) dut (
      .next_addr(next_addr),
      .out_addr (out_addr),
      .clk      (clk),
      .reset    (reset)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] loaded(input logic [31:0] a);
`ifdef PC_WORD_ALIGN_EN
      return (a / 32'd4) * 32'd4;
`else
      return a;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] exp);
      n_checks++;
      assert (out_addr === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, out_addr, exp);
      end
   endtask

   // Drive an address at the falling edge, then check one edge later.
   task automatic cycle(input logic [31:0] a, input string tag);
      @(negedge clk);
      next_addr = a;
      @(posedge clk);
      #1;
      model_pc = reset ? loaded(RV) : loaded(a);
      check(tag, model_pc);
   endtask

   initial begin
      logic [31:0] a;
      logic        r;

      // Asynchronous reset with no clock edge yet.
      #1 reset = 1'b1;
      #1 check("reset_immediate", loaded(RV));

      // Clock edges ignored while reset held.
      cycle(32'd123, "reset_hold_1");
      cycle(32'hDEAD_BEEF, "reset_hold_2");

      @(negedge clk);
      reset = 1'b0;
      cycle(32'd34, "first_after_reset");

      cycle(32'd69, "seq_69");
      cycle(32'd23, "seq_23");
      cycle(32'd24, "seq_24");
      cycle(32'd25, "seq_25");

      // Hold: next_addr changes between edges.
      cycle(32'd69, "hold_load");
      #2 next_addr = 32'd23;
      #1 check("hold_mid", loaded(32'd69));
      @(posedge clk);
      #1 check("hold_next_edge", loaded(32'd23));

      // Constant input gives constant output.
      cycle(32'd25, "const_1");
      cycle(32'd25, "const_2");

      // Async reset pulse between edges.
      @(negedge clk);
      #1 reset = 1'b1;
      #1 check("async_mid", loaded(RV));
      next_addr = 32'd777;
      @(posedge clk);
      #1 check("async_held", loaded(RV));
      @(negedge clk);
      reset = 1'b0;
      cycle(32'd1000, "after_async");

      // Boundary patterns.
      cycle(32'hFFFF_FFFF, "all_ones");
      cycle(32'h0000_0000, "all_zeros");
      cycle(32'hAAAA_5555, "alt_bits");
      cycle(32'h8000_0001, "msb_lsb");

      // Reset asserted exactly on a rising edge.
      @(negedge clk);
      next_addr = 32'h1234_5678;
      @(posedge clk);
      reset = 1'b1;
      #1 check("reset_on_edge", loaded(RV));
      @(negedge clk);
      reset = 1'b0;
      cycle(32'h0BAD_F00D, "after_edge_reset");

      // Randomized traffic with occasional reset pulses.
      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         r = ($urandom_range(0, 15) == 0);
         @(negedge clk);
         reset = r;
         next_addr = a;
         #1;
         if (r) model_pc = loaded(RV);
         check("rand_pre_edge", model_pc);
         @(posedge clk);
         #1;
         model_pc = r ? loaded(RV) : loaded(a);
         check("rand_edge", model_pc);
         #2 next_addr = $urandom;
         #1 check("rand_hold", model_pc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
